// File: rtl/reg_dbg_pkg.sv
// reg_dbg_pkg: shared types for the register-file dump reader.
package reg_dbg_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dump_state_t;
endpackage

// File: rtl/reg_file_dumper.sv
// reg_file_dumper: walks register-file addresses 0..2**A-1 and streams each word over valid/ready.
module reg_file_dumper
    import reg_dbg_pkg::*;
#(
    parameter int W = 8,
    parameter int A = 3
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Abort,
    output logic [A-1:0] RdAddr,
    input  logic [W-1:0] RdData,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [W-1:0] OutData,
    output logic [A-1:0] OutAddr,
    output logic         OutLast,
    output logic         Busy,
    output logic         Done
);
    localparam logic [A:0] LAST = (A+1)'(2**A - 1);

    dump_state_t  state_q, state_d;
    logic [A:0]   cnt_q, cnt_d;
    logic         valid_q, valid_d, last_q, last_d;
    logic [W-1:0] data_q, data_d;
    logic [A-1:0] addr_q, addr_d;
    logic         load;

    // A new word enters the output register only when the previous one is gone or leaving.
    assign load = (state_q == READ) && (!valid_q || OutReady);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        last_d  = last_q;
        if (Abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (state_q == IDLE && Start) begin
            state_d = READ;
            cnt_d   = '0;
        end else if (load) begin
            data_d  = RdData;
            addr_d  = cnt_q[A-1:0];
            last_d  = cnt_q == LAST;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == LAST ? DRAIN : READ;
        end else if (state_q == DRAIN && valid_q && OutReady) begin
            valid_d = 1'b0;
            state_d = DONE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

    assign RdAddr   = cnt_q[A-1:0];
    assign OutValid = valid_q;
    assign OutData  = data_q;
    assign OutAddr  = addr_q;
    assign OutLast  = last_q;
    assign Busy     = state_q == READ || state_q == DRAIN;
    assign Done     = state_q == DONE;
endmodule

// File: tb/tb_reg_file_dumper.sv
// tb_reg_file_dumper: table-driven timing checks plus a scoreboard over randomized dumps.
module tb_reg_file_dumper;
    localparam int W = 8;
    localparam int A = 3;
    localparam int N = 2**A;

    logic         Clk = 0, Reset = 0, Start = 0, Abort = 0, OutReady = 0;
    logic [A-1:0] RdAddr, OutAddr;
    logic [W-1:0] RdData, OutData;
    logic         OutValid, OutLast, Busy, Done;
    logic [W-1:0] mem [N];
    int           errors = 0, checks = 0;

    reg_file_dumper #(.W(W), .A(A)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .RdAddr(RdAddr), .RdData(RdData),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .OutAddr(OutAddr), .OutLast(OutLast), .Busy(Busy), .Done(Done)
    );

    assign RdData = mem[RdAddr];
    always #5 Clk = ~Clk;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic [A-1:0] a;
        logic         l;
        logic         b;
        logic         dn;
        logic [A-1:0] ra;
    } vec_t;
    vec_t tbl [N+3];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < N; i++) mem[i] = W'(8'h10 + i);
    endtask

    // Scoreboard: expected stream is the snapshot of mem at Start, in address order.
    task automatic dump(input int mode, input bit restart);
        logic [W-1:0] snap [N];
        int           hs = 0, dones = 0, post = 0, cyc = 0;
        bit           pv = 0, pr = 0, want = 0;
        logic [W-1:0] pd = '0;
        logic [A-1:0] pa = '0;
        logic         pl = 0;
        snap = mem;
        Start = 1;
        step();
        Start = 0;
        while (cyc < 300 && post < 4) begin
            OutReady = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            Start = restart && (cyc == 3 || Done);
            if (pv && !pr) chk("hold", {OutValid, OutData, OutAddr, OutLast}, {1'b1, pd, pa, pl});
            if (want) chk("done_pulse", Done, 1);
            want = 0;
            if (Done) dones++;
            if (OutValid && OutReady) begin
                if (hs < N) chk("word", {OutAddr, OutData, OutLast}, {hs[A-1:0], snap[hs], hs == N-1});
                else chk("extra_word", hs, N-1);
                hs++;
                want = hs == N;
            end
            if (mode == 2 && hs > 0) mem[$urandom_range(0, hs-1)] = W'($urandom);
            if (hs >= N) post++;
            pv = OutValid; pr = OutReady; pd = OutData; pa = OutAddr; pl = OutLast;
            step();
            cyc++;
        end
        Start = 0;
        chk("hs_count", hs, N);
        chk("done_count", dones, 1);
    endtask

    initial begin
        int dn;
        #2;
        chk("rst_out", {OutValid, OutData, OutAddr, OutLast, Done, Busy, RdAddr}, '0);
        step();
        Reset = 1;
        step();
        chk("idle_out", {OutValid, Busy, Done}, '0);

        // Full-throughput timing, row j = state after edge k+j where Start was sampled at k.
        for (int j = 0; j < N+3; j++) begin
            tbl[j].v  = j >= 1 && j <= N;
            tbl[j].d  = W'(8'h10 + j - 1);
            tbl[j].a  = A'(j - 1);
            tbl[j].l  = j == N;
            tbl[j].b  = j <= N;
            tbl[j].dn = j == N+1;
            tbl[j].ra = j <= N ? A'(j % N) : '0;
        end
        preload();
        OutReady = 1;
        Start = 1;
        step();
        Start = 0;
        for (int j = 0; j < N+3; j++) begin
            chk($sformatf("tbl%0d_ctl", j), {OutValid, Busy, Done, RdAddr}, {tbl[j].v, tbl[j].b, tbl[j].dn, tbl[j].ra});
            if (tbl[j].v) chk($sformatf("tbl%0d_word", j), {OutData, OutAddr, OutLast}, {tbl[j].d, tbl[j].a, tbl[j].l});
            step();
        end

        dump(0, 0);
        dump(1, 0);

        // Long stall after word 0.
        OutReady = 0;
        Start = 1;
        step();
        Start = 0;
        step();
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (Done) dn++;
        end
        chk("stall", {OutValid, OutData, RdAddr, Busy}, {1'b1, W'(8'h10), A'(1), 1'b1});
        chk("stall_done", dn, 0);
        OutReady = 1;
        for (int i = 0; i < N+3; i++) step();
        chk("stall_end", {OutValid, Busy}, '0);

        // Abort after word-3 handshake.
        Start = 1;
        step();
        Start = 0;
        for (int i = 0; i < 5; i++) step();
        Abort = 1;
        step();
        Abort = 0;
        chk("abort", {OutValid, Busy, Done}, '0);
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (Done || OutValid) dn++;
            step();
        end
        chk("abort_quiet", dn, 0);
        dump(0, 0);

        // Asynchronous reset while word 5 is on the output.
        Start = 1;
        step();
        Start = 0;
        for (int i = 0; i < 6; i++) step();
        chk("pre_rst", {OutValid, OutAddr}, {1'b1, A'(5)});
        Reset = 0;
        #1;
        chk("async_rst", {OutValid, OutData, OutAddr, OutLast, Done, Busy, RdAddr}, '0);
        Reset = 1;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (OutValid || Busy || Done) dn++;
        end
        chk("post_rst_idle", dn, 0);

        dump(0, 1);
        dump(0, 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) mem[i] = W'($urandom);
            dump(2, r[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
